// File: rtl/rom_vector_fetch.sv
// rom_vector_fetch
//   Exception vector fetch sequencer in front of the boot ROM. Arbitrates
//   reset > NMI > IRQ. Reads the two vector bytes (low at base, high at
//   base+1) from the top of ROM. Offers the assembled address to the CPU's
//   PC-load logic over a valid/ready handshake.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   nmi_req             NMI request, rising-edge sensitive
//   irq_req, irq_mask   IRQ request (level) and CPU I flag (1 blocks IRQ)
//   rom_addr/cs/oe      ROM address, chip select, output enable
//   rom_data            ROM read data (only sampled while reading)
//   vec_valid/ready     handshake to the PC-load logic
//   vec_addr, vec_src   assembled vector {hi,lo}; source 01 rst/10 nmi/11 irq
//   busy                high whenever a fetch or hand-off is in progress
module rom_vector_fetch #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    nmi_req,
  input  logic                    irq_req,
  input  logic                    irq_mask,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  output logic                    rom_cs,
  output logic                    rom_oe,
  input  logic [DATA_WIDTH-1:0]   rom_data,
  output logic                    vec_valid,
  input  logic                    vec_ready,
  output logic [2*DATA_WIDTH-1:0] vec_addr,
  output logic [1:0]              vec_src,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, VALID} state_t;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_RST  = 2'b01;
  localparam logic [1:0] SRC_NMI  = 2'b10;
  localparam logic [1:0] SRC_IRQ  = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [ADDR_WIDTH-1:0] NMI_BASE = ALL_ONES - ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] RST_BASE = ALL_ONES - ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] IRQ_BASE = ALL_ONES - ADDR_WIDTH'(1);

  state_t                state, state_next;
  logic [1:0]            src_q, sel_src;
  logic [ADDR_WIDTH-1:0] base_q, sel_base;
  logic [DATA_WIDTH-1:0] lo_q, hi_q;
  logic                  rst_pend, nmi_pend, nmi_prev;
  logic                  nmi_edge, handshake;

  assign nmi_edge  = nmi_req & ~nmi_prev;
  assign handshake = (state == VALID) & vec_ready;

  // Selection in IDLE. A fresh NMI edge counts in the same cycle it arrives,
  // so an NMI rising alongside a held IRQ wins immediately.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    sel_src    = SRC_NONE;
    sel_base   = '0;
    case (state)
      IDLE: begin
        if (rst_pend) begin
          sel_src  = SRC_RST;
          sel_base = RST_BASE;
        end else if (nmi_pend || nmi_edge) begin
          sel_src  = SRC_NMI;
          sel_base = NMI_BASE;
        end else if (irq_req && !irq_mask) begin
          sel_src  = SRC_IRQ;
          sel_base = IRQ_BASE;
        end
        if (sel_src != SRC_NONE) state_next = RD_LO;
      end
      RD_LO:   state_next = RD_HI;
      RD_HI:   state_next = VALID;
      VALID:   if (vec_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      src_q  <= SRC_NONE;
      base_q <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
    end else begin
      state <= state_next;
      // Source and base are committed at selection; later requests or IRQ
      // changes cannot disturb the fetch in progress.
      if (state == IDLE && sel_src != SRC_NONE) begin
        src_q  <= sel_src;
        base_q <= sel_base;
      end
      if (state == RD_LO) lo_q <= rom_data;
      if (state == RD_HI) hi_q <= rom_data;
    end
  end

  // Pending flags. Reset re-arms the reset vector and drops any NMI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_pend <= 1'b1;
      nmi_pend <= 1'b0;
      nmi_prev <= 1'b0;
    end else begin
      nmi_prev <= nmi_req;
      if (handshake && src_q == SRC_RST) rst_pend <= 1'b0;
      // A new edge coinciding with the NMI handshake keeps the flag set.
      if (nmi_edge)                           nmi_pend <= 1'b1;
      else if (handshake && src_q == SRC_NMI) nmi_pend <= 1'b0;
    end
  end

  // Outputs decode only registered state; vec_ready never reaches them.
  assign rom_cs    = (state == RD_LO) || (state == RD_HI);
  assign rom_oe    = rom_cs;
  assign rom_addr  = (state == RD_LO) ? base_q :
                     (state == RD_HI) ? base_q + ADDR_WIDTH'(1) : '0;
  assign vec_valid = (state == VALID);
  assign vec_addr  = {hi_q, lo_q};
  assign vec_src   = src_q;
  assign busy      = (state != IDLE);

endmodule
